// File: rtl/urp_pcie_tx_link_arbiter.sv
// PCIe TX data link layer egress arbiter: NAK/ACK DLLPs, replayed TLPs and new TLPs
// share one registered single-beat stream toward the physical layer.
module urp_pcie_tx_link_arbiter #(
  parameter int unsigned TLP_W       = 268,
  parameter int unsigned ACK_LATENCY = 16,
  parameter logic [7:0]  DLLP_ACK    = 8'h00,
  parameter logic [7:0]  DLLP_NAK    = 8'h10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [TLP_W-1:0] new_tlp_i,
  input  logic             new_valid_i,
  output logic             new_ready_o,
  input  logic [TLP_W-1:0] rpl_tlp_i,
  input  logic             rpl_valid_i,
  output logic             rpl_ready_o,
  input  logic             rpl_active_i,
  input  logic             ack_req_i,
  input  logic             nak_req_i,
  input  logic [11:0]      ack_seq_i,
  output logic [TLP_W-1:0] link_data_o,
  output logic             link_is_dllp_o,
  output logic             link_valid_o,
  input  logic             link_ready_i,
  output logic             nak_sched_o
);

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_NAK,
    SEL_RPL,
    SEL_ACK,
    SEL_NEW
  } sel_e;

  localparam logic [7:0] LAT = 8'(ACK_LATENCY);

  logic [TLP_W-1:0] r_link_data;
  logic             r_link_dllp;
  logic             r_link_valid;
  logic             r_ack_pend;
  logic [11:0]      r_ack_seq;
  logic [7:0]       r_ack_timer;
  logic             r_nak_pend;
  logic             r_nak_sched;
  logic [11:0]      r_nak_seq;

  logic             w_advance;
  logic             w_ack_urgent;
  logic             w_ack_acc;
  logic             w_nak_acc;
  sel_e             w_sel;
  logic [TLP_W-1:0] w_win_data;
  logic             w_win_dllp;

  function automatic logic [TLP_W-1:0] f_dllp(input logic [7:0] typ, input logic [11:0] seq);
    logic [TLP_W-1:0] v;
    v       = '0;
    v[31:0] = {typ, 12'h000, seq};
    return v;
  endfunction

  assign w_advance    = !r_link_valid || link_ready_i;
  assign w_ack_urgent = r_ack_pend && (r_ack_timer == LAT);
  // A simultaneous NAK request overrules the ACK request entirely.
  assign w_ack_acc    = ack_req_i && !nak_req_i;
  assign w_nak_acc    = nak_req_i && !r_nak_sched;

  always_comb begin
    w_sel = SEL_NONE;
    if (w_advance) begin
      if (r_nak_pend)                        w_sel = SEL_NAK;
      else if (rpl_valid_i)                  w_sel = SEL_RPL;
      else if (w_ack_urgent)                 w_sel = SEL_ACK;
      else if (new_valid_i && !rpl_active_i) w_sel = SEL_NEW;
      else if (r_ack_pend)                   w_sel = SEL_ACK;
    end
  end

  always_comb begin
    w_win_data = '0;
    w_win_dllp = 1'b0;
    case (w_sel)
      SEL_NAK: begin
        w_win_data = f_dllp(DLLP_NAK, r_nak_seq);
        w_win_dllp = 1'b1;
      end
      SEL_ACK: begin
        w_win_data = f_dllp(DLLP_ACK, r_ack_seq);
        w_win_dllp = 1'b1;
      end
      SEL_RPL: w_win_data = rpl_tlp_i;
      SEL_NEW: w_win_data = new_tlp_i;
      default: ;
    endcase
  end

  assign rpl_ready_o = (w_sel == SEL_RPL);
  assign new_ready_o = (w_sel == SEL_NEW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_link_data  <= '0;
      r_link_dllp  <= 1'b0;
      r_link_valid <= 1'b0;
    end else if (w_advance) begin
      r_link_valid <= (w_sel != SEL_NONE);
      if (w_sel != SEL_NONE) begin
        r_link_data <= w_win_data;
        r_link_dllp <= w_win_dllp;
      end
    end
  end

  // ACK coalescing: newest sequence wins; a NAK also carries the acknowledgement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack_pend  <= 1'b0;
      r_ack_seq   <= '0;
      r_ack_timer <= '0;
    end else if (w_ack_acc) begin
      r_ack_pend  <= 1'b1;
      r_ack_seq   <= ack_seq_i;
      r_ack_timer <= '0;
    end else if (w_sel == SEL_ACK || w_sel == SEL_NAK) begin
      r_ack_pend  <= 1'b0;
      r_ack_timer <= '0;
    end else if (r_ack_pend && r_ack_timer != LAT) begin
      r_ack_timer <= r_ack_timer + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nak_pend  <= 1'b0;
      r_nak_sched <= 1'b0;
      r_nak_seq   <= '0;
    end else if (w_nak_acc) begin
      r_nak_pend  <= 1'b1;
      r_nak_sched <= 1'b1;
      r_nak_seq   <= ack_seq_i;
    end else begin
      if (w_sel == SEL_NAK) r_nak_pend  <= 1'b0;
      if (w_ack_acc)        r_nak_sched <= 1'b0;
    end
  end

  assign link_data_o    = r_link_data;
  assign link_is_dllp_o = r_link_dllp;
  assign link_valid_o   = r_link_valid;
  assign nak_sched_o    = r_nak_sched;

endmodule

// File: tb/tb_urp_pcie_tx_link_arbiter.sv
// Self-checking bench for urp_pcie_tx_link_arbiter: directed scenarios plus
// randomized traffic compared against a behavioural arbitration model.
module tb_urp_pcie_tx_link_arbiter;

  localparam int TLP_W       = 268;
  localparam int ACK_LATENCY = 16;
  localparam int W_NONE = 0, W_NAK = 1, W_RPL = 2, W_ACK = 3, W_NEW = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [TLP_W-1:0] new_tlp_i;
  logic             new_valid_i;
  logic             new_ready_o;
  logic [TLP_W-1:0] rpl_tlp_i;
  logic             rpl_valid_i;
  logic             rpl_ready_o;
  logic             rpl_active_i;
  logic             ack_req_i;
  logic             nak_req_i;
  logic [11:0]      ack_seq_i;
  logic [TLP_W-1:0] link_data_o;
  logic             link_is_dllp_o;
  logic             link_valid_o;
  logic             link_ready_i;
  logic             nak_sched_o;

  always #5 clk = ~clk;

  urp_pcie_tx_link_arbiter #(
    .TLP_W(TLP_W), .ACK_LATENCY(ACK_LATENCY), .DLLP_ACK(8'h00), .DLLP_NAK(8'h10)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .new_tlp_i(new_tlp_i), .new_valid_i(new_valid_i), .new_ready_o(new_ready_o),
    .rpl_tlp_i(rpl_tlp_i), .rpl_valid_i(rpl_valid_i), .rpl_ready_o(rpl_ready_o),
    .rpl_active_i(rpl_active_i),
    .ack_req_i(ack_req_i), .nak_req_i(nak_req_i), .ack_seq_i(ack_seq_i),
    .link_data_o(link_data_o), .link_is_dllp_o(link_is_dllp_o),
    .link_valid_o(link_valid_o), .link_ready_i(link_ready_i),
    .nak_sched_o(nak_sched_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk_eq(input string tag, input logic [TLP_W-1:0] act, input logic [TLP_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Behavioural model: pending-work flags, an unbounded ACK age and the egress beat.
  logic             m_valid;
  logic [TLP_W-1:0] m_data;
  logic             m_dllp;
  logic             ma_pend;
  logic [11:0]      ma_seq;
  int               ma_age;
  logic             mn_pend;
  logic             mn_sched;
  logic [11:0]      mn_seq;
  int               last_win;
  logic             obs_new;
  logic             obs_rpl;

  function automatic logic [TLP_W-1:0] dllp(input logic [7:0] t, input logic [11:0] s);
    logic [TLP_W-1:0] v;
    v       = '0;
    v[31:0] = {t, 12'h000, s};
    return v;
  endfunction

  function automatic logic [TLP_W-1:0] rnd_tlp();
    logic [287:0] t;
    for (int i = 0; i < 9; i++) t[i*32 +: 32] = $urandom;
    return t[TLP_W-1:0];
  endfunction

  task automatic model_reset();
    m_valid = 0; m_data = '0; m_dllp = 0;
    ma_pend = 0; ma_seq = '0; ma_age = 0;
    mn_pend = 0; mn_sched = 0; mn_seq = '0;
    last_win = W_NONE;
  endtask

  task automatic idle();
    new_tlp_i = '0; new_valid_i = 0; rpl_tlp_i = '0; rpl_valid_i = 0;
    rpl_active_i = 0; ack_req_i = 0; nak_req_i = 0; ack_seq_i = '0;
  endtask

  task automatic step();
    logic adv;
    int   win;
    #1;
    adv = !m_valid || link_ready_i;
    win = W_NONE;
    if (adv) begin
      if (mn_pend)                                 win = W_NAK;
      else if (rpl_valid_i)                        win = W_RPL;
      else if (ma_pend && ma_age >= ACK_LATENCY)   win = W_ACK;
      else if (new_valid_i && !rpl_active_i)       win = W_NEW;
      else if (ma_pend)                            win = W_ACK;
    end
    last_win = win;
    obs_new  = new_ready_o;
    obs_rpl  = rpl_ready_o;
    chk_eq("rpl_ready", TLP_W'(rpl_ready_o), TLP_W'(win == W_RPL));
    chk_eq("new_ready", TLP_W'(new_ready_o), TLP_W'(win == W_NEW));
    @(posedge clk);
    if (adv) begin
      m_valid = (win != W_NONE);
      case (win)
        W_NAK: begin m_data = dllp(8'h10, mn_seq); m_dllp = 1; end
        W_ACK: begin m_data = dllp(8'h00, ma_seq); m_dllp = 1; end
        W_RPL: begin m_data = rpl_tlp_i; m_dllp = 0; end
        W_NEW: begin m_data = new_tlp_i; m_dllp = 0; end
        default: ;
      endcase
    end
    if (win == W_NAK) begin mn_pend = 0; ma_pend = 0; ma_age = 0; end
    else if (win == W_ACK) begin ma_pend = 0; ma_age = 0; end
    else if (ma_pend) ma_age++;
    if (ack_req_i && !nak_req_i) begin
      ma_pend = 1; ma_seq = ack_seq_i; ma_age = 0; mn_sched = 0;
    end
    if (nak_req_i && !mn_sched) begin
      mn_pend = 1; mn_sched = 1; mn_seq = ack_seq_i;
    end
    #1;
    chk_eq("link_valid", TLP_W'(link_valid_o), TLP_W'(m_valid));
    chk_eq("nak_sched", TLP_W'(nak_sched_o), TLP_W'(mn_sched));
    if (m_valid) begin
      chk_eq("link_data", link_data_o, m_data);
      chk_eq("link_is_dllp", TLP_W'(link_is_dllp_o), TLP_W'(m_dllp));
    end
  endtask

  initial begin
    int               cnt;
    int               got;
    logic [TLP_W-1:0] held;
    logic [11:0]      lseq;

    idle();
    link_ready_i = 1;
    rst_n = 0;
    model_reset();
    #12;
    chk_eq("rst_valid", TLP_W'(link_valid_o), '0);
    chk_eq("rst_data", link_data_o, '0);
    chk_eq("rst_dllp", TLP_W'(link_is_dllp_o), '0);
    chk_eq("rst_nak_sched", TLP_W'(nak_sched_o), '0);
    @(negedge clk) rst_n = 1;

    // Lone ACK with no traffic
    ack_req_i = 1; ack_seq_i = 12'h005; step();
    ack_req_i = 0; step();
    chk_eq("t1_valid", TLP_W'(link_valid_o), TLP_W'(1));
    chk_eq("t1_data", link_data_o, TLP_W'(32'h0000_0005));
    chk_eq("t1_dllp", TLP_W'(link_is_dllp_o), TLP_W'(1));
    step();
    chk_eq("t1_drop", TLP_W'(link_valid_o), '0);

    // ACK latency timer against continuous new TLPs
    new_valid_i = 1; new_tlp_i = rnd_tlp(); ack_req_i = 1; ack_seq_i = 12'h010; step();
    ack_req_i = 0;
    cnt = 0; got = 0;
    for (int i = 0; i < 40 && got == 0; i++) begin
      new_tlp_i = rnd_tlp(); step();
      if (obs_new) cnt++;
      if (link_valid_o && link_is_dllp_o) got = 1;
    end
    chk_eq("t2_ack_seen", TLP_W'(got), TLP_W'(1));
    chk_eq("t2_tlp_count", TLP_W'(cnt), TLP_W'(16));
    chk_eq("t2_ack_data", link_data_o, TLP_W'(32'h0000_0010));
    new_tlp_i = rnd_tlp(); step();
    chk_eq("t2_next_tlp", TLP_W'({link_valid_o, link_is_dllp_o}), TLP_W'(2'b10));
    new_valid_i = 0; step();

    // Coalescing while the egress is stalled
    link_ready_i = 0; new_valid_i = 1; new_tlp_i = rnd_tlp(); step();
    new_valid_i = 0;
    for (int s = 1; s <= 3; s++) begin
      ack_req_i = 1; ack_seq_i = 12'(s); step();
    end
    ack_req_i = 0; link_ready_i = 1;
    cnt = 0; lseq = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (link_valid_o && link_is_dllp_o) begin cnt++; lseq = link_data_o[11:0]; end
    end
    chk_eq("t3_ack_count", TLP_W'(cnt), TLP_W'(1));
    chk_eq("t3_ack_seq", TLP_W'(lseq), TLP_W'(12'h003));

    // NAK scheduling and suppression
    nak_req_i = 1; ack_seq_i = 12'h020; step();
    chk_eq("t4_sched_set", TLP_W'(nak_sched_o), TLP_W'(1));
    ack_seq_i = 12'h021; step();
    nak_req_i = 0;
    chk_eq("t4_nak_data", link_data_o, TLP_W'(32'h1000_0020));
    chk_eq("t4_nak_dllp", TLP_W'(link_is_dllp_o), TLP_W'(1));
    step();
    chk_eq("t4_sched_hold", TLP_W'(nak_sched_o), TLP_W'(1));
    ack_req_i = 1; ack_seq_i = 12'h030; step();
    ack_req_i = 0;
    chk_eq("t4_sched_clr", TLP_W'(nak_sched_o), '0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (link_valid_o && link_is_dllp_o && link_data_o[31:24] == 8'h10) cnt++;
    end
    chk_eq("t4_extra_nak", TLP_W'(cnt), '0);

    // Replay blocks new TLPs; pending ACK waits for replay to finish
    rpl_active_i = 1; rpl_valid_i = 1; new_valid_i = 1;
    new_tlp_i = rnd_tlp(); rpl_tlp_i = rnd_tlp();
    ack_req_i = 1; ack_seq_i = 12'h044; step();
    ack_req_i = 0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      rpl_tlp_i = rnd_tlp(); new_tlp_i = rnd_tlp(); step();
      if (obs_rpl && !obs_new) cnt++;
    end
    chk_eq("t5_rpl_only", TLP_W'(cnt), TLP_W'(5));
    rpl_valid_i = 0; step();
    chk_eq("t5_ack_data", link_data_o, TLP_W'(32'h0000_0044));
    chk_eq("t5_ack_dllp", TLP_W'(link_is_dllp_o), TLP_W'(1));
    rpl_active_i = 0; new_valid_i = 0; step();

    // Stall stability, then reset mid-transfer
    nak_req_i = 1; ack_seq_i = 12'h055; step();
    nak_req_i = 0; step();
    new_valid_i = 1; new_tlp_i = rnd_tlp(); step();
    held = link_data_o;
    link_ready_i = 0; rpl_valid_i = 1;
    for (int i = 0; i < 5; i++) begin
      new_tlp_i = rnd_tlp(); rpl_tlp_i = rnd_tlp(); step();
      chk_eq("t6_stable", link_data_o, held);
      chk_eq("t6_readies", TLP_W'({obs_rpl, obs_new}), '0);
    end
    #2 rst_n = 0;
    #1;
    chk_eq("t6_rst_valid", TLP_W'(link_valid_o), '0);
    chk_eq("t6_rst_sched", TLP_W'(nak_sched_o), '0);
    chk_eq("t6_rst_data", link_data_o, '0);
    idle(); link_ready_i = 1; model_reset();
    @(negedge clk) rst_n = 1;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      new_valid_i  = ($urandom % 4) != 0;
      new_tlp_i    = rnd_tlp();
      rpl_valid_i  = ($urandom % 3) == 0;
      rpl_tlp_i    = rnd_tlp();
      rpl_active_i = rpl_valid_i ? (($urandom % 4) != 0) : (($urandom % 5) == 0);
      ack_req_i    = ((i / 500) % 2 == 1) ? (($urandom % 40) == 0) : (($urandom % 6) == 0);
      nak_req_i    = ($urandom % 20) == 0;
      ack_seq_i    = 12'($urandom);
      link_ready_i = ($urandom % 4) != 0;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
